// File: rtl/weight_accum_select.sv
// Weight accumulator and best-move selector: sums scanner weights into a saturating score
// table and scans it in row-major order for the highest-scoring empty cell.
//
// state  | meaning
// IDLE   | accepting weight writes, waiting for clearScores / startSelect
// CLEAR  | zeroing one table entry per cycle, addr 0..CELLS-1
// SELECT | one drain cycle, then occupancy lookups + compares over the table
// DONE   | result valid for one cycle, writes accepted again
module weight_accum_select #(
  parameter int BRD_W    = 19,
  parameter int BRD_H    = 19,
  parameter int WEIGHT_W = 4,
  parameter int SCORE_W  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enaWRITE,
  input  logic [4:0]          XlocV,
  input  logic [4:0]          YlocV,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic                clearScores,
  input  logic                startSelect,
  output logic [4:0]          occX,
  output logic [4:0]          occY,
  input  logic                occIn,
  output logic                busy,
  output logic                doneSelect,
  output logic [4:0]          bestX,
  output logic [4:0]          bestY,
  output logic [SCORE_W-1:0]  bestScore,
  output logic                noMove,
  output logic                wrOverrun
);

  localparam int CELLS = BRD_W * BRD_H;
  localparam int AW = $clog2(CELLS + 2);
  localparam logic [AW-1:0] CLEAR_LAST = AW'(CELLS - 1);
  localparam logic [AW-1:0] SEL_LEN = AW'(CELLS + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [WEIGHT_W-1:0] W_FORCE = WEIGHT_W'(8);

  typedef enum logic [1:0] {IDLE, CLEAR, SELECT, DONE} stateType;

  stateType state, nextState;
  logic bootClear;
  logic [AW-1:0] stepCnt;
  logic [4:0] cellX, cellY;
  logic [AW-1:0] cellAddr;
  logic issue;

  logic inRange, acceptWrite;
  logic [AW-1:0] wrAddr;
  logic s1Valid, s2Valid;
  logic [AW-1:0] s1Addr, s2Addr;
  logic [WEIGHT_W-1:0] s1Weight;
  logic [SCORE_W-1:0] s2Sum, s1Sum, base;
  logic [SCORE_W:0] sumWide;

  logic cmpValid;
  logic [AW-1:0] cmpAddr;
  logic [4:0] cmpX, cmpY;
  logic [SCORE_W-1:0] cmpScore;
  logic takeCand;
  logic runValid, runValidN;
  logic [4:0] runX, runY, runXN, runYN;
  logic [SCORE_W-1:0] runScore, runScoreN;

  logic [SCORE_W-1:0] scoreMem [0:CELLS-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bootClear || clearScores) nextState = CLEAR;
        else if (startSelect)         nextState = SELECT;
      end
      CLEAR:   if (stepCnt == '0) nextState = IDLE;
      SELECT:  if (stepCnt == '0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == CLEAR) || (state == SELECT);
    doneSelect = (state == DONE);
    occX       = issue ? cellX : 5'd0;
    occY       = issue ? cellY : 5'd0;
  end

  // Forces a table clear on the first edge after every reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bootClear <= 1'b1;
    else          bootClear <= 1'b0;
  end

  // SELECT spends its first cycle (stepCnt == SEL_LEN) letting the write pipeline drain.
  assign issue = (state == SELECT) && (stepCnt != SEL_LEN) && (stepCnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stepCnt  <= '0;
      cellX    <= '0;
      cellY    <= '0;
      cellAddr <= '0;
    end else if (state == CLEAR || state == SELECT) begin
      stepCnt <= stepCnt - 1'b1;
      if (state == CLEAR || issue) begin
        if (cellX == 5'(BRD_W - 1)) begin
          cellX <= '0;
          cellY <= cellY + 1'b1;
        end else begin
          cellX <= cellX + 1'b1;
        end
        cellAddr <= cellAddr + 1'b1;
      end
    end else begin
      stepCnt  <= (nextState == CLEAR) ? CLEAR_LAST : SEL_LEN;
      cellX    <= '0;
      cellY    <= '0;
      cellAddr <= '0;
    end
  end

  assign inRange     = (int'(XlocV) < BRD_W) && (int'(YlocV) < BRD_H);
  assign acceptWrite = enaWRITE && inRange && (state == IDLE || state == DONE);
  assign wrAddr      = AW'(YlocV) * AW'(BRD_W) + AW'(XlocV);

  // A same-cell write one cycle behind picks up the not-yet-committed stage-2 sum.
  always_comb begin
    base    = (s2Valid && s2Addr == s1Addr) ? s2Sum : scoreMem[s1Addr];
    sumWide = {1'b0, base} + (SCORE_W + 1)'(s1Weight);
    if (s1Weight == W_FORCE)  s1Sum = SCORE_MAX;
    else if (sumWide[SCORE_W]) s1Sum = SCORE_MAX;
    else                       s1Sum = sumWide[SCORE_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid  <= 1'b0;
      s1Addr   <= '0;
      s1Weight <= '0;
      s2Valid  <= 1'b0;
      s2Addr   <= '0;
      s2Sum    <= '0;
    end else begin
      s1Valid  <= acceptWrite;
      s1Addr   <= wrAddr;
      s1Weight <= weight;
      s2Valid  <= s1Valid && (state != CLEAR);
      s2Addr   <= s1Addr;
      s2Sum    <= s1Sum;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) scoreMem[cellAddr] <= '0;
    else if (s2Valid)   scoreMem[s2Addr] <= s2Sum;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               wrOverrun <= 1'b0;
    else if (state == CLEAR && stepCnt == '0)   wrOverrun <= 1'b0;
    else if (enaWRITE && inRange && busy)       wrOverrun <= 1'b1;
  end

  assign cmpScore = scoreMem[cmpAddr];
  assign takeCand = cmpValid && !occIn && (!runValid || cmpScore > runScore);

  always_comb begin
    runValidN = runValid | takeCand;
    runXN     = takeCand ? cmpX : runX;
    runYN     = takeCand ? cmpY : runY;
    runScoreN = takeCand ? cmpScore : runScore;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmpValid <= 1'b0;
      cmpAddr  <= '0;
      cmpX     <= '0;
      cmpY     <= '0;
      runValid <= 1'b0;
      runX     <= '0;
      runY     <= '0;
      runScore <= '0;
    end else begin
      cmpValid <= issue;
      cmpAddr  <= cellAddr;
      cmpX     <= cellX;
      cmpY     <= cellY;
      if (state == SELECT) begin
        runValid <= runValidN;
        runX     <= runXN;
        runY     <= runYN;
        runScore <= runScoreN;
      end else begin
        runValid <= 1'b0;
        runX     <= '0;
        runY     <= '0;
        runScore <= '0;
      end
    end
  end

  // Results land on the edge into DONE so they are valid alongside doneSelect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bestX     <= '0;
      bestY     <= '0;
      bestScore <= '0;
      noMove    <= 1'b0;
    end else if (state == SELECT && stepCnt == '0) begin
      bestX     <= runXN;
      bestY     <= runYN;
      bestScore <= runScoreN;
      noMove    <= !runValidN;
    end
  end

endmodule

// File: tb/tb_weight_accum_select.sv
// Bench for weight_accum_select: directed scenarios plus randomized write/occupancy rounds
// checked against a score-table model that scans for the best empty cell.
module tb_weight_accum_select;

  localparam int BRD_W = 19;
  localparam int BRD_H = 19;
  localparam int CELLS = BRD_W * BRD_H;
  localparam int SMAX  = 255;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enaWRITE = 1'b0;
  logic [4:0] XlocV = '0;
  logic [4:0] YlocV = '0;
  logic [3:0] weight = '0;
  logic       clearScores = 1'b0;
  logic       startSelect = 1'b0;
  logic [4:0] occX, occY;
  logic       occIn = 1'b0;
  logic       busy, doneSelect, noMove, wrOverrun;
  logic [4:0] bestX, bestY;
  logic [7:0] bestScore;

  int vecCnt = 0;
  int errCnt = 0;
  int refScore [CELLS];
  bit occBoard [CELLS];

  weight_accum_select dut (
    .clk(clk), .reset_n(reset_n), .enaWRITE(enaWRITE), .XlocV(XlocV), .YlocV(YlocV),
    .weight(weight), .clearScores(clearScores), .startSelect(startSelect),
    .occX(occX), .occY(occY), .occIn(occIn), .busy(busy), .doneSelect(doneSelect),
    .bestX(bestX), .bestY(bestY), .bestScore(bestScore), .noMove(noMove), .wrOverrun(wrOverrun)
  );

  always #5 clk = ~clk;

  // Board memory: one-cycle read latency.
  always @(posedge clk) occIn <= occBoard[int'(occY) * BRD_W + int'(occX)];

  task automatic checkVal(input string tag, input int got, input int exp);
    vecCnt++;
    if (got != exp) begin
      errCnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelWrite(input int x, input int y, input int w);
    int a;
    if (x < BRD_W && y < BRD_H) begin
      a = y * BRD_W + x;
      if (w == 8) refScore[a] = SMAX;
      else refScore[a] = (refScore[a] + w > SMAX) ? SMAX : refScore[a] + w;
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < CELLS; i++) refScore[i] = 0;
  endtask

  task automatic modelSelect(output int ex, output int ey, output int es, output int enm);
    int best;
    best = -1; ex = 0; ey = 0;
    for (int a = 0; a < CELLS; a++) begin
      if (!occBoard[a] && refScore[a] > best) begin
        best = refScore[a];
        ex = a % BRD_W;
        ey = a / BRD_W;
      end
    end
    enm = (best < 0) ? 1 : 0;
    es = (best < 0) ? 0 : best;
  endtask

  task automatic writeCell(input int x, input int y, input int w);
    enaWRITE = 1'b1;
    XlocV = 5'(x);
    YlocV = 5'(y);
    weight = 4'(w);
    modelWrite(x, y, w);
    @(negedge clk);
    enaWRITE = 1'b0;
  endtask

  task automatic waitClear(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    checkVal(tag, cnt, CELLS);
    modelClear();
  endtask

  task automatic doClear(input string tag);
    clearScores = 1'b1;
    @(negedge clk);
    clearScores = 1'b0;
    waitClear(tag);
  endtask

  // withWr: write issued in the start cycle (must commit). midWr: write during SELECT (dropped).
  task automatic runSelect(input string tag, input bit withWr, input bit midWr,
                           input int wx, input int wy, input int ww);
    int ex, ey, es, enm, cnt;
    bit seen;
    startSelect = 1'b1;
    if (withWr) begin
      enaWRITE = 1'b1; XlocV = 5'(wx); YlocV = 5'(wy); weight = 4'(ww);
      modelWrite(wx, wy, ww);
    end
    modelSelect(ex, ey, es, enm);
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      startSelect = 1'b0;
      enaWRITE = 1'b0;
      if (cnt == 1) checkVal({tag, "_busy"}, int'(busy), 1);
      if (midWr && cnt == 50) begin
        enaWRITE = 1'b1; XlocV = 5'(wx); YlocV = 5'(wy); weight = 4'(ww);
      end
      if (doneSelect) seen = 1'b1;
    end
    checkVal({tag, "_latency"}, seen ? cnt : -1, 364);
    if (seen) begin
      checkVal({tag, "_noMove"}, int'(noMove), enm);
      if (enm == 0) begin
        checkVal({tag, "_bestX"}, int'(bestX), ex);
        checkVal({tag, "_bestY"}, int'(bestY), ey);
        checkVal({tag, "_bestScore"}, int'(bestScore), es);
      end
      @(negedge clk);
      checkVal({tag, "_donePulse"}, int'(doneSelect), 0);
    end
  endtask

  initial begin
    int lx, ly, x, y, w, r, cnt;
    bit seenDone;
    modelClear();
    for (int i = 0; i < CELLS; i++) occBoard[i] = 1'b0;

    repeat (3) @(negedge clk);
    checkVal("rst_busy", int'(busy), 0);
    checkVal("rst_done", int'(doneSelect), 0);
    checkVal("rst_best", int'({bestX, bestY, bestScore}), 0);
    checkVal("rst_flags", int'({noMove, wrOverrun}), 0);
    reset_n = 1'b1;
    @(negedge clk);
    waitClear("boot_clear_len");
    runSelect("zero_table", 1'b0, 1'b0, 0, 0, 0);

    writeCell(3, 4, 2);
    writeCell(3, 4, 5);
    runSelect("fwd_sum", 1'b0, 1'b0, 0, 0, 0);

    doClear("clr_len");
    for (int i = 0; i < 8; i++) writeCell(0, 0, 7);
    writeCell(0, 0, 8);
    writeCell(18, 18, 8);
    for (int i = 0; i < 40; i++) writeCell(1, 0, 7);
    runSelect("sat_tie", 1'b0, 1'b0, 0, 0, 0);
    occBoard[0] = 1'b1;
    occBoard[CELLS - 1] = 1'b1;
    runSelect("sat_add", 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < CELLS; i++) occBoard[i] = 1'b0;

    doClear("clr_len2");
    writeCell(5, 5, 8);
    writeCell(6, 5, 7);
    writeCell(6, 5, 7);
    writeCell(2, 2, 3);
    occBoard[5 * BRD_W + 5] = 1'b1;
    runSelect("occ_skip", 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < CELLS; i++) occBoard[i] = 1'b1;
    runSelect("all_occ", 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < CELLS; i++) occBoard[i] = 1'b0;

    runSelect("busy_wr", 1'b0, 1'b1, 3, 4, 5);
    checkVal("ovr_set", int'(wrOverrun), 1);
    runSelect("busy_wr_after", 1'b0, 1'b0, 0, 0, 0);
    doClear("clr_len3");
    checkVal("ovr_clr", int'(wrOverrun), 0);
    writeCell(19, 2, 5);
    @(negedge clk);
    checkVal("ovr_oob", int'(wrOverrun), 0);
    runSelect("oob_drop", 1'b0, 1'b0, 0, 0, 0);
    runSelect("start_wr", 1'b1, 1'b0, 0, 0, 6);

    for (int round = 0; round < 5; round++) begin
      doClear("rnd_clr");
      for (int i = 0; i < CELLS; i++) occBoard[i] = ($urandom_range(0, 3) == 0);
      lx = 0; ly = 0;
      for (int i = 0; i < 60; i++) begin
        if (i > 0 && $urandom_range(0, 2) == 0) begin
          x = lx; y = ly;
        end else begin
          x = ($urandom_range(0, 15) == 0) ? $urandom_range(19, 31) : $urandom_range(0, 18);
          y = $urandom_range(0, 18);
        end
        r = $urandom_range(0, 24);
        w = (r == 24) ? 8 : r % 8;
        writeCell(x, y, w);
        lx = x; ly = y;
        if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      runSelect("rnd_sel", 1'b1, 1'b0, $urandom_range(0, 18), $urandom_range(0, 18),
                $urandom_range(0, 7));
    end

    for (int i = 0; i < CELLS; i++) occBoard[i] = 1'b0;
    writeCell(7, 7, 5);
    startSelect = 1'b1;
    seenDone = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      startSelect = 1'b0;
      if (doneSelect) seenDone = 1'b1;
    end
    reset_n = 1'b0;
    #1;
    checkVal("rst_mid_busy", int'(busy), 0);
    checkVal("rst_mid_done", int'(doneSelect), 0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (doneSelect) seenDone = 1'b1;
    end
    checkVal("rst_mid_nodone", int'(seenDone), 0);
    reset_n = 1'b1;
    @(negedge clk);
    waitClear("rst_reclear_len");
    runSelect("rst_reclear_sel", 1'b0, 1'b0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
